// File: rtl/online_pkg.sv
// Shared types for the on-line (MSD-first) signed-digit arithmetic stages.
// Holds the borrow-save digit type, the adder framing FSM states and the adder's on-line delay.
package online_pkg;

    localparam int ONLINE_DELAY = 2;

    typedef struct packed {
        logic plus;
        logic minus;
    } sd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH1,
        ST_FLUSH2
    } adder_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/online_adder_lane.sv
// One lane of the radix-2 on-line adder: two carry-free stages plus the
// g / y- / w history and the registered result digit (t appears as z.minus).
module online_adder_lane
    import online_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      advance,
    input  logic      zero_inject,
    input  sd_digit_t x_digit,
    input  sd_digit_t y_digit,
    output sd_digit_t z_digit
);

    logic xp, xm, yp, ym;
    logic h, g, w_next, t_next;
    logic g_reg, y_minus_reg, w_reg;
    sd_digit_t z_reg;

    always_comb begin
        xp = x_digit.plus  & ~zero_inject;
        xm = x_digit.minus & ~zero_inject;
        yp = y_digit.plus  & ~zero_inject;
        ym = y_digit.minus & ~zero_inject;
        // Stage 1: full adder on (x+, ~x-, y+) gives a = 2h - g.
        h = maj3(xp, ~xm, yp);
        g = ~(xp ^ ~xm ^ yp);
        // Stage 2 for the previous position: b = h - g_prev - y-_prev = w - 2t.
        w_next = h ^ g_reg ^ y_minus_reg;
        t_next = maj3(~h, g_reg, y_minus_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_reg       <= 1'b0;
            y_minus_reg <= 1'b0;
            w_reg       <= 1'b0;
            z_reg       <= '0;
        end else if (advance) begin
            g_reg       <= g;
            y_minus_reg <= ym;
            w_reg       <= w_next;
            z_reg       <= '{plus: w_reg, minus: t_next};
        end
    end

    assign z_digit = z_reg;

endmodule

// File: rtl/online_adder_lanes.sv
// Multi-lane on-line adder with shared valid/ready framing and a two-cycle zero flush.
// Optional ONLINE_ADDER_SUB_EN adds a per-lane sub input (z = x - y), latched on the first slice.
module online_adder_lanes
    import online_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DIGITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [LANES-1:0] x_plus,
    input  logic [LANES-1:0] x_minus,
    input  logic [LANES-1:0] y_plus,
    input  logic [LANES-1:0] y_minus,
`ifdef ONLINE_ADDER_SUB_EN
    input  logic [LANES-1:0] sub,
`endif
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic [LANES-1:0] z_plus,
    output logic [LANES-1:0] z_minus
);

    adder_state_t     state_reg;
    logic             out_valid_reg, out_first_reg, out_last_reg;
    logic             first_pending_reg;
    logic             advance, zero_inject;
    logic [LANES-1:0] y_swap;

    // Operand length comes from in_last alone; DIGITS only documents the legal range.
    if (DIGITS < 2 || DIGITS > 64) begin : g_digits_out_of_range
    end

    always_comb begin
        in_ready    = (state_reg == ST_IDLE) || (state_reg == ST_RUN);
        zero_inject = !in_ready;
        advance     = in_ready ? in_valid : 1'b1;
    end

`ifdef ONLINE_ADDER_SUB_EN
    logic [LANES-1:0] sub_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_reg <= '0;
        end else if (state_reg == ST_IDLE && in_valid) begin
            sub_reg <= sub;
        end
    end

    always_comb begin
        y_swap = (state_reg == ST_IDLE) ? sub : sub_reg;
    end
`else
    always_comb begin
        y_swap = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            out_valid_reg     <= 1'b0;
            out_first_reg     <= 1'b0;
            out_last_reg      <= 1'b0;
            first_pending_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    out_valid_reg <= 1'b0;
                    out_first_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                    if (in_valid) begin
                        first_pending_reg <= 1'b1;
                        state_reg         <= in_last ? ST_FLUSH1 : ST_RUN;
                    end
                end
                ST_RUN: begin
                    out_valid_reg <= in_valid;
                    out_first_reg <= in_valid & first_pending_reg;
                    out_last_reg  <= 1'b0;
                    if (in_valid) begin
                        first_pending_reg <= 1'b0;
                        if (in_last) begin
                            state_reg <= ST_FLUSH1;
                        end
                    end
                end
                ST_FLUSH1: begin
                    out_valid_reg     <= 1'b1;
                    out_first_reg     <= first_pending_reg;
                    out_last_reg      <= 1'b0;
                    first_pending_reg <= 1'b0;
                    state_reg         <= ST_FLUSH2;
                end
                default: begin
                    out_valid_reg     <= 1'b1;
                    out_first_reg     <= first_pending_reg;
                    out_last_reg      <= 1'b1;
                    first_pending_reg <= 1'b0;
                    state_reg         <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_first = out_first_reg;
    assign out_last  = out_last_reg;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        sd_digit_t x_d, y_d, z_d;

        assign x_d = '{plus: x_plus[gi], minus: x_minus[gi]};
        assign y_d = y_swap[gi] ? '{plus: y_minus[gi], minus: y_plus[gi]}
                                : '{plus: y_plus[gi],  minus: y_minus[gi]};

        online_adder_lane u_lane (
            .clk         (clk),
            .rst         (rst),
            .advance     (advance),
            .zero_inject (zero_inject),
            .x_digit     (x_d),
            .y_digit     (y_d),
            .z_digit     (z_d)
        );

        assign z_plus[gi]  = z_d.plus;
        assign z_minus[gi] = z_d.minus;
    end

endmodule

// File: tb/tb_online_adder_lanes.sv
// Directed bench for online_adder_lanes: framing, flush, stalls, reset and digit-weighted sums.
// Build with ONLINE_ADDER_SUB_EN defined to also exercise the per-lane subtract option.
module tb_online_adder_lanes;
    import online_pkg::*;

    localparam int LANES  = 4;
    localparam int DIGITS = 4;
    localparam int NOPS   = 4;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, in_last;
    logic [LANES-1:0] x_plus, x_minus, y_plus, y_minus;
    logic             out_valid, out_first, out_last;
    logic [LANES-1:0] z_plus, z_minus;
`ifdef ONLINE_ADDER_SUB_EN
    logic [LANES-1:0] sub;
`endif

    online_adder_lanes #(.LANES(LANES), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .x_plus    (x_plus),
        .x_minus   (x_minus),
        .y_plus    (y_plus),
        .y_minus   (y_minus),
`ifdef ONLINE_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last),
        .z_plus    (z_plus),
        .z_minus   (z_minus)
    );

    always #5 clk = ~clk;

    // Digits per operand / lane, MSD first, values in {-1,0,1}; sums are scaled by 2^DIGITS.
    int xd [NOPS][LANES][DIGITS] = '{
        '{'{0,0,0,0},    '{0,0,0,0},   '{0,0,0,0},       '{0,0,0,0}},
        '{'{1,0,0,0},    '{1,1,1,1},   '{-1,-1,-1,-1},   '{0,0,0,1}},
        '{'{1,-1,0,1},   '{1,0,1,0},   '{1,-1,1,-1},     '{-1,0,0,0}},
        '{'{1,1,0,0},    '{1,1,0,0},   '{1,1,0,0},       '{1,1,0,0}}
    };
    int yd [NOPS][LANES][DIGITS] = '{
        '{'{0,0,0,0},    '{0,0,0,0},   '{0,0,0,0},       '{0,0,0,0}},
        '{'{1,0,0,0},    '{1,1,1,1},   '{-1,0,0,0},      '{0,-1,0,0}},
        '{'{-1,1,0,-1},  '{0,1,0,1},   '{1,-1,1,-1},     '{-1,0,0,0}},
        '{'{0,1,0,0},    '{0,1,0,0},   '{0,1,0,0},       '{0,1,0,0}}
    };
    int exp_sum [NOPS][LANES] = '{
        '{0, 0, 0, 0},
        '{16, 30, -23, -3},
        '{0, 15, 10, -16},
        '{8, 16, 16, 16}
    };
    int gaps [NOPS][DIGITS] = '{'{0,0,0,0}, '{0,2,0,1}, '{1,0,3,0}, '{0,1,0,0}};
    bit zero_as_11 [NOPS] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [LANES-1:0] sub_first [NOPS] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};
    logic [LANES-1:0] sub_later [NOPS] = '{4'b0000, 4'b0000, 4'b0000, 4'b1110};

    int n_checks = 0;
    int n_pass   = 0;
    int ocount;
    int acc [LANES];
    bit expect_zero;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [1:0] enc(input int d, input bit z11);
        if (d == 1)  return 2'b10;
        if (d == -1) return 2'b01;
        return z11 ? 2'b11 : 2'b00;
    endfunction

    // Advance one clock, then sample and accumulate any output slice.
    task automatic tick();
        @(posedge clk);
        #1;
        if (out_valid) begin
            check("out_first", out_first, ocount == 0);
            check("out_last", out_last, ocount == DIGITS);
            if (expect_zero) check("z_zero", {z_plus, z_minus}, 0);
            if (ocount <= DIGITS) begin
                for (int l = 0; l < LANES; l++)
                    acc[l] += (int'(z_plus[l]) - int'(z_minus[l])) * (1 << (DIGITS - ocount));
            end
            ocount++;
        end
    endtask

    task automatic drive_digit(input int op, input int j, input bit last);
        int n;
        n = 0;
        while (!in_ready && n < 10) begin
            in_valid = 1'b0;
            tick();
            n++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        for (int l = 0; l < LANES; l++) begin
            {x_plus[l], x_minus[l]} = enc(xd[op][l][j], zero_as_11[op]);
            {y_plus[l], y_minus[l]} = enc(yd[op][l][j], zero_as_11[op]);
        end
`ifdef ONLINE_ADDER_SUB_EN
        sub = (j == 0) ? sub_first[op] : sub_later[op];
`endif
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_op(input int op);
        ocount      = 0;
        expect_zero = (op == 0);
        for (int l = 0; l < LANES; l++) acc[l] = 0;
        for (int j = 0; j < DIGITS; j++) begin
            repeat (gaps[op][j]) tick();
            drive_digit(op, j, j == DIGITS - 1);
        end
        check($sformatf("ready_flush_op%0d", op), in_ready, 0);
        repeat (ONLINE_DELAY) tick();
        tick();
        check($sformatf("count_op%0d", op), ocount, DIGITS + 1);
        for (int l = 0; l < LANES; l++)
            check($sformatf("sum_op%0d_l%0d", op, l), acc[l], exp_sum[op][l]);
        $display("op %0d: slices=%0d sums=%0d %0d %0d %0d", op, ocount, acc[0], acc[1], acc[2], acc[3]);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        x_plus   = '0;
        x_minus  = '0;
        y_plus   = '0;
        y_minus  = '0;
`ifdef ONLINE_ADDER_SUB_EN
        sub      = '0;
`endif
        ocount      = 0;
        expect_zero = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_first", out_first, 0);
        check("rst_out_last", out_last, 0);
        check("rst_z", {z_plus, z_minus}, 0);
        rst = 1'b0;
        tick();

        run_op(0);
        run_op(1);
        run_op(2);

        // Reset in the middle of an operand, after three digits.
        ocount      = 0;
        expect_zero = 1'b0;
        for (int j = 0; j < 3; j++) drive_digit(2, j, 1'b0);
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_first", out_first, 0);
        check("mid_rst_z", {z_plus, z_minus}, 0);
        check("mid_rst_in_ready", in_ready, 1);
        rst = 1'b0;
        $display("reset mid-run: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        run_op(2);

`ifdef ONLINE_ADDER_SUB_EN
        run_op(3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
